ysyx_22040000_load_unit: RTL and testbench

Read-side counterpart of the NPC's register/write datapath: accepts one load request from the execute stage, issues a single AXI4-Lite read (AR/R channels) to data memory, then aligns and extends the returned word. The result goes to write-back with the destination register index. One outstanding transaction at a time. Sits between EXU and the data-memory bus arbiter.

---
 rtl/ysyx_22040000_lsu_pkg.sv | 22 ++
 rtl/ysyx_22040000_load_unit_if.sv | 44 ++++
 rtl/ysyx_22040000_load_align.sv | 51 +++++
 rtl/ysyx_22040000_reg.sv | 20 ++
 rtl/ysyx_22040000_load_unit.sv | 119 +++++++++++
 tb/tb_ysyx_22040000_load_unit.sv | 204 ++++++++++++++++++++
 6 files changed

// File: rtl/ysyx_22040000_lsu_pkg.sv
// Shared definitions for the load/store unit: load funct3 codes, load FSM
// state encoding and AXI response codes.
package ysyx_22040000_lsu_pkg;

  localparam int REG_IDX_W = 5;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_AR   = 2'b01,
    ST_R    = 2'b10,
    ST_RESP = 2'b11
  } load_state_t;

endpackage

// File: rtl/ysyx_22040000_load_unit_if.sv
// Request, AXI4-Lite read (AR/R) and write-back response signals of the load
// unit. The master view belongs to the load unit, the slave view to its peers.
interface ysyx_22040000_load_unit_if
  import ysyx_22040000_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                 req_valid;
  logic                 req_ready;
  logic [ADDR_W-1:0]    req_addr;
  logic [2:0]           req_funct3;
  logic [REG_IDX_W-1:0] req_rd;

  logic [ADDR_W-1:0]    araddr;
  logic                 arvalid;
  logic                 arready;

  logic [DATA_W-1:0]    rdata;
  logic [1:0]           rresp;
  logic                 rvalid;
  logic                 rready;

  logic                 resp_valid;
  logic                 resp_ready;
  logic [DATA_W-1:0]    resp_data;
  logic [REG_IDX_W-1:0] resp_rd;
  logic                 resp_err;

  modport master (
    input  req_valid, req_addr, req_funct3, req_rd,
    input  arready, rdata, rresp, rvalid, resp_ready,
    output req_ready, araddr, arvalid, rready,
    output resp_valid, resp_data, resp_rd, resp_err
  );

  modport slave (
    output req_valid, req_addr, req_funct3, req_rd,
    output arready, rdata, rresp, rvalid, resp_ready,
    input  req_ready, araddr, arvalid, rready,
    input  resp_valid, resp_data, resp_rd, resp_err
  );

endinterface

// File: rtl/ysyx_22040000_load_align.sv
// Combinational load alignment/extension of a read word, plus the
// legality/misalignment check applied to an incoming request.
module ysyx_22040000_load_align
  import ysyx_22040000_lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        offset,
  input  logic [2:0]        funct3,
  output logic [DATA_W-1:0] data,
  input  logic [1:0]        chk_offset,
  input  logic [2:0]        chk_funct3,
  output logic              chk_illegal
);

  logic [DATA_W-1:0]        shifted;
  logic signed [7:0]        byte_s;
  logic signed [15:0]       half_s;
  logic signed [DATA_W-1:0] byte_ext;
  logic signed [DATA_W-1:0] half_ext;

  always_comb begin
    shifted  = rdata >> {offset, 3'b000};
    byte_s   = signed'(shifted[7:0]);
    half_s   = signed'(shifted[15:0]);
    byte_ext = DATA_W'(byte_s);
    half_ext = DATA_W'(half_s);
    data     = '0;
    case (funct3)
      F3_LB:   data = byte_ext;
      F3_LBU:  data = {{(DATA_W-8){1'b0}}, shifted[7:0]};
      F3_LH:   data = half_ext;
      F3_LHU:  data = {{(DATA_W-16){1'b0}}, shifted[15:0]};
      F3_LW:   data = shifted;
      default: data = '0;
    endcase
  end

  // Halfwords must be 2-byte aligned, words 4-byte aligned; other funct3 are not loads.
  always_comb begin
    chk_illegal = 1'b1;
    case (chk_funct3)
      F3_LB, F3_LBU: chk_illegal = 1'b0;
      F3_LH, F3_LHU: chk_illegal = chk_offset[0];
      F3_LW:         chk_illegal = |chk_offset;
      default:       chk_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/ysyx_22040000_reg.sv
// Generic enable register with synchronous active-low reset to RESET_VAL.
module ysyx_22040000_reg #(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wen,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  always_ff @(posedge clk) begin
    if (!rst)
      dout <= RESET_VAL;
    else if (wen)
      dout <= din;
  end

endmodule

// File: rtl/ysyx_22040000_load_unit.sv
// Load unit: accepts one load from EXU, performs a single AXI4-Lite read and
// returns the aligned, extended value with its rd index to WBU.
module ysyx_22040000_load_unit
  import ysyx_22040000_lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic                    clk,
  input logic                    rst,
  ysyx_22040000_load_unit_if.master bus
);

  load_state_t state, state_nxt;

  logic                 cap_en;
  logic                 res_en;
  logic                 res_err_d;
  logic [DATA_W-1:0]    res_data_d;

  logic [ADDR_W-1:0]    addr_q;
  logic [2:0]           f3_q;
  logic [REG_IDX_W-1:0] rd_q;
  logic [DATA_W-1:0]    data_q;
  logic                 err_q;

  logic [DATA_W-1:0]    ext_data;
  logic                 req_illegal;

  ysyx_22040000_load_align #(.DATA_W(DATA_W)) u_align (
    .rdata       (bus.rdata),
    .offset      (addr_q[1:0]),
    .funct3      (f3_q),
    .data        (ext_data),
    .chk_offset  (bus.req_addr[1:0]),
    .chk_funct3  (bus.req_funct3),
    .chk_illegal (req_illegal)
  );

  always_ff @(posedge clk) begin
    if (!rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cap_en     = 1'b0;
    res_en     = 1'b0;
    res_err_d  = 1'b0;
    res_data_d = '0;
    case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          cap_en = 1'b1;
          // Illegal requests skip the bus entirely and answer with an error.
          if (req_illegal) begin
            res_en    = 1'b1;
            res_err_d = 1'b1;
            state_nxt = ST_RESP;
          end else begin
            state_nxt = ST_AR;
          end
        end
      end
      ST_AR: begin
        if (bus.arready)
          state_nxt = ST_R;
      end
      ST_R: begin
        if (bus.rvalid) begin
          res_en    = 1'b1;
          state_nxt = ST_RESP;
          if (bus.rresp != RESP_OKAY)
            res_err_d = 1'b1;
          else
            res_data_d = ext_data;
        end
      end
      ST_RESP: begin
        if (bus.resp_ready)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  ysyx_22040000_reg #(.WIDTH(ADDR_W)) u_addr_q (
    .clk(clk), .rst(rst), .wen(cap_en), .din(bus.req_addr), .dout(addr_q)
  );

  ysyx_22040000_reg #(.WIDTH(3)) u_f3_q (
    .clk(clk), .rst(rst), .wen(cap_en), .din(bus.req_funct3), .dout(f3_q)
  );

  ysyx_22040000_reg #(.WIDTH(REG_IDX_W)) u_rd_q (
    .clk(clk), .rst(rst), .wen(cap_en), .din(bus.req_rd), .dout(rd_q)
  );

  ysyx_22040000_reg #(.WIDTH(DATA_W)) u_data_q (
    .clk(clk), .rst(rst), .wen(res_en), .din(res_data_d), .dout(data_q)
  );

  ysyx_22040000_reg #(.WIDTH(1)) u_err_q (
    .clk(clk), .rst(rst), .wen(res_en), .din(res_err_d), .dout(err_q)
  );

  // All outputs come from the state register or captured fields only.
  assign bus.req_ready  = (state == ST_IDLE);
  assign bus.arvalid    = (state == ST_AR);
  assign bus.araddr     = {addr_q[ADDR_W-1:2], 2'b00};
  assign bus.rready     = (state == ST_R);
  assign bus.resp_valid = (state == ST_RESP);
  assign bus.resp_data  = data_q;
  assign bus.resp_rd    = rd_q;
  assign bus.resp_err   = err_q;

endmodule

// File: tb/tb_ysyx_22040000_load_unit.sv
// Scoreboard bench for the load unit: each load pushes its expected response,
// a negedge monitor compares whatever the unit presents to write-back.
module tb_ysyx_22040000_load_unit;
  import ysyx_22040000_lsu_pkg::*;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  exp_t sb[$];

  ysyx_22040000_load_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  ysyx_22040000_load_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Scoreboard side: anything shown to write-back must match the oldest entry.
  always @(negedge clk) begin
    if (rst && bus.resp_valid) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_resp", 32'd1, 32'd0);
      end else begin
        check("resp_data", bus.resp_data, sb[0].data);
        check("resp_rd", 32'(bus.resp_rd), 32'(sb[0].rd));
        check("resp_err", 32'(bus.resp_err), 32'(sb[0].err));
        if (bus.resp_ready)
          void'(sb.pop_front());
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    check({tag, "_arvalid"}, 32'(bus.arvalid), 32'd0);
    check({tag, "_araddr"}, bus.araddr, 32'd0);
    check({tag, "_rready"}, 32'(bus.rready), 32'd0);
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_data"}, bus.resp_data, 32'd0);
    check({tag, "_resp_rd"}, 32'(bus.resp_rd), 32'd0);
    check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after the RESP handshake.
  task automatic run_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd,
                          input logic [31:0] rdat, input logic [1:0] rr,
                          input int ar_dly, input int r_dly, input int resp_dly,
                          input bit illegal, input logic [31:0] exp_araddr,
                          input logic [31:0] exp_data, input bit exp_err);
    exp_t e;
    bit   done;
    e.data = exp_data;
    e.rd   = rd;
    e.err  = exp_err;
    sb.push_back(e);

    bus.req_valid  = 1'b1;
    bus.req_addr   = addr;
    bus.req_funct3 = f3;
    bus.req_rd     = rd;
    @(negedge clk);
    check("req_ready_idle", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;

    if (!illegal) begin
      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
        bus.arready = (n >= ar_dly);
        @(negedge clk);
        check("arvalid", 32'(bus.arvalid), 32'd1);
        check("araddr", bus.araddr, exp_araddr);
        check("req_ready_in_ar", 32'(bus.req_ready), 32'd0);
        done = bus.arready;
        @(posedge clk); #1;
      end
      if (!done) check("ar_timeout", 32'd0, 32'd1);
      bus.arready = 1'b0;

      done = 1'b0;
      for (int n = 0; n < 40 && !done; n++) begin
        bus.rvalid = (n >= r_dly);
        bus.rdata  = rdat;
        bus.rresp  = rr;
        @(negedge clk);
        check("rready", 32'(bus.rready), 32'd1);
        check("arvalid_in_r", 32'(bus.arvalid), 32'd0);
        check("req_ready_in_r", 32'(bus.req_ready), 32'd0);
        done = bus.rvalid;
        @(posedge clk); #1;
      end
      if (!done) check("r_timeout", 32'd0, 32'd1);
      bus.rvalid = 1'b0;
      bus.rdata  = 32'h0;
      bus.rresp  = 2'b00;
    end

    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      bus.resp_ready = (n >= resp_dly);
      @(negedge clk);
      check("resp_valid", 32'(bus.resp_valid), 32'd1);
      check("req_ready_in_resp", 32'(bus.req_ready), 32'd0);
      check("arvalid_in_resp", 32'(bus.arvalid), 32'd0);
      check("rready_in_resp", 32'(bus.rready), 32'd0);
      done = bus.resp_ready;
      @(posedge clk); #1;
    end
    if (!done) check("resp_timeout", 32'd0, 32'd1);
    bus.resp_ready = 1'b0;

    @(negedge clk);
    check("req_ready_after_resp", 32'(bus.req_ready), 32'd1);
    check("resp_valid_after_resp", 32'(bus.resp_valid), 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    rst            = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_funct3 = 3'b000;
    bus.req_rd     = 5'd0;
    bus.arready    = 1'b0;
    bus.rdata      = 32'h0;
    bus.rresp      = 2'b00;
    bus.rvalid     = 1'b0;
    bus.resp_ready = 1'b0;

    @(posedge clk); #1;
    @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b1;

    // Zero-wait loads across every extract rule
    run_load(32'h8000_0004, F3_LW,  5'd5,  32'h1234_5678, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0004, 32'h1234_5678, 1'b0);
    run_load(32'h8000_0003, F3_LB,  5'd6,  32'h80AA_BBCC, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0000, 32'hFFFF_FF80, 1'b0);
    run_load(32'h8000_0003, F3_LBU, 5'd7,  32'h80AA_BBCC, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0000, 32'h0000_0080, 1'b0);
    run_load(32'h8000_0002, F3_LH,  5'd8,  32'h8001_0000, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0000, 32'hFFFF_8001, 1'b0);
    run_load(32'h8000_0002, F3_LHU, 5'd9,  32'h8001_0000, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0000, 32'h0000_8001, 1'b0);
    run_load(32'h8000_0101, F3_LB,  5'd10, 32'h0000_7F00, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0100, 32'h0000_007F, 1'b0);
    run_load(32'h8000_0100, F3_LH,  5'd11, 32'hFFFF_7234, 2'b00, 0, 0, 0, 1'b0, 32'h8000_0100, 32'h0000_7234, 1'b0);

    // Illegal requests: misaligned halfword/word, non-load funct3
    run_load(32'h8000_0001, F3_LH,  5'd12, 32'h0, 2'b00, 0, 0, 0, 1'b1, 32'h0, 32'h0, 1'b1);
    run_load(32'h8000_0002, F3_LW,  5'd13, 32'h0, 2'b00, 0, 0, 1, 1'b1, 32'h0, 32'h0, 1'b1);
    run_load(32'h8000_0000, 3'b011, 5'd14, 32'h0, 2'b00, 0, 0, 0, 1'b1, 32'h0, 32'h0, 1'b1);

    // Bus error response
    run_load(32'h8000_0020, F3_LW,  5'd15, 32'hDEAD_BEEF, 2'b10, 0, 0, 0, 1'b0, 32'h8000_0020, 32'h0, 1'b1);

    // Wait states on every handshake
    run_load(32'h8000_0010, F3_LW,  5'd16, 32'hCAFE_F00D, 2'b00, 3, 2, 2, 1'b0, 32'h8000_0010, 32'hCAFE_F00D, 1'b0);

    // Reset while waiting in R: no response, outputs return to reset values
    bus.req_valid  = 1'b1;
    bus.req_addr   = 32'h8000_0044;
    bus.req_funct3 = F3_LW;
    bus.req_rd     = 5'd17;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.arready   = 1'b1;
    @(posedge clk); #1;
    bus.arready = 1'b0;
    @(negedge clk);
    check("rready_before_rst", 32'(bus.rready), 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midrst");
    @(posedge clk); #1;

    run_load(32'h8000_0048, F3_LW,  5'd18, 32'h0BAD_CAFE, 2'b00, 1, 1, 0, 1'b0, 32'h8000_0048, 32'h0BAD_CAFE, 1'b0);

    repeat (2) @(posedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
